// File: rtl/cache_arbiter.sv
// Shares the single pmem line port between the I-cache (fills only) and the D-cache (fills and writebacks).
// One transfer at a time; when both sides are waiting, the side not served last goes next.
module cache_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,
  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t state, state_next;
  logic   last_grant_d;
  logic   i_req, d_req;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

  // last_grant_d remembers who finished most recently so a tie favours the other side
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
    end else begin
      state <= state_next;
      if (pmem_resp && (state == SERVE_I)) begin
        last_grant_d <= 1'b0;
      end else if (pmem_resp && (state == SERVE_D)) begin
        last_grant_d <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next        = state;
    pmem_read         = 1'b0;
    pmem_write        = 1'b0;
    pmem_address      = '0;
    pmem_wdata        = '0;
    icache_pmem_resp  = 1'b0;
    icache_pmem_rdata = '0;
    dcache_pmem_resp  = 1'b0;
    dcache_pmem_rdata = '0;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          state_next = last_grant_d ? SERVE_I : SERVE_D;
        end else if (i_req) begin
          state_next = SERVE_I;
        end else if (d_req) begin
          state_next = SERVE_D;
        end
      end
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = icache_pmem_address & LINE_MASK;
        if (pmem_resp) begin
          icache_pmem_resp  = 1'b1;
          icache_pmem_rdata = pmem_rdata;
          state_next        = DONE;
        end
      end
      SERVE_D: begin
        // a writeback wins if the D-cache raises both strobes
        pmem_read    = dcache_pmem_read & ~dcache_pmem_write;
        pmem_write   = dcache_pmem_write;
        pmem_address = dcache_pmem_address & LINE_MASK;
        pmem_wdata   = dcache_pmem_wdata;
        if (pmem_resp) begin
          dcache_pmem_resp  = 1'b1;
          dcache_pmem_rdata = pmem_rdata;
          state_next        = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomised scoreboard bench for cache_arbiter: requester agents push expected transfers,
// a monitor predicts grant order/timing from the arbitration rules and checks every pmem cycle.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         icache_pmem_read;
  logic [31:0]  icache_pmem_address;
  logic [255:0] icache_pmem_rdata;
  logic         icache_pmem_resp;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [31:0]  dcache_pmem_address;
  logic [255:0] dcache_pmem_wdata;
  logic [255:0] dcache_pmem_rdata;
  logic         dcache_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  cache_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .OFFSET_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
    .icache_pmem_rdata(icache_pmem_rdata), .icache_pmem_resp(icache_pmem_resp),
    .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_rdata(dcache_pmem_rdata), .dcache_pmem_resp(dcache_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic [31:0]  addr;
    logic         rd;
    logic         wr;
    logic [255:0] wdata;
    int           raise_cycle;
  } req_t;

  req_t         pend_i[$];
  req_t         pend_d[$];
  int           grant_log[$];
  int           cyc = 0;
  int           last_served = 0;
  int           earliest_grant = 0;
  bit           active = 0;
  int           cur_side = 0;
  int           mem_delay = 0;
  bit           auto_mem = 1;
  logic [255:0] mem_line = '0;
  int           n_checks = 0;
  int           n_fail = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic logic [31:0] lineBase(input logic [31:0] a);
    return (a / 32) * 32;
  endfunction

  function automatic logic [255:0] randLine();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    n_checks = n_checks + 1;
    if (actual !== expected) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // one request from side 0 (I) or 1 (D), held until its resp, then dropped
  task automatic applyStimulus(input int side, input logic [31:0] addr, input logic rd,
                               input logic wr, input logic [255:0] wdata);
    req_t r;
    int   waited;
    logic seen;
    @(posedge clk); #1;
    r.addr = addr; r.rd = rd; r.wr = wr; r.wdata = wdata; r.raise_cycle = cyc;
    if (side == 0) begin
      pend_i.push_back(r);
      icache_pmem_read    = 1'b1;
      icache_pmem_address = addr;
    end else begin
      pend_d.push_back(r);
      dcache_pmem_read    = rd;
      dcache_pmem_write   = wr;
      dcache_pmem_address = addr;
      dcache_pmem_wdata   = wdata;
    end
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
      seen = (side == 0) ? icache_pmem_resp : dcache_pmem_resp;
    end while (!seen && waited < 300);
    if (!seen) begin
      checkOutput("resp_timeout", 256'(seen), 256'(1));
      if (side == 0 && pend_i.size() > 0) pend_i.delete(0);
      if (side == 1 && pend_d.size() > 0) pend_d.delete(0);
      if (active && cur_side == side) active = 0;
    end
    @(posedge clk); #1;
    if (side == 0) begin
      icache_pmem_read    = 1'b0;
      icache_pmem_address = $urandom;
    end else begin
      dcache_pmem_read    = 1'b0;
      dcache_pmem_write   = 1'b0;
      dcache_pmem_address = $urandom;
      dcache_pmem_wdata   = randLine();
    end
  endtask

  task automatic randomTraffic(input int side, input int count, input int max_gap);
    int op;
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(0, max_gap)) @(posedge clk);
      op = $urandom_range(0, 2);
      if (side == 0) applyStimulus(0, $urandom, 1'b1, 1'b0, '0);
      else applyStimulus(1, $urandom, op != 1, op != 0, randLine());
    end
  endtask

  // memory model: answers each transfer after mem_delay cycles (random when 0) with a fresh line
  initial begin
    int d;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (auto_mem && !rst && (pmem_read || pmem_write)) begin
        d = (mem_delay == 0) ? $urandom_range(1, 5) : mem_delay;
        repeat (d) @(posedge clk);
        #1;
        mem_line   = randLine();
        pmem_rdata = mem_line;
        pmem_resp  = 1'b1;
        @(posedge clk); #1;
        pmem_resp  = 1'b0;
        pmem_rdata = randLine();
      end
    end
  end

  // monitor: predicts which side must be granted and when, then checks each cycle of the transfer
  always @(negedge clk) begin
    bit   pi, pd;
    int   first, g_exp;
    req_t r;
    if (rst) begin
      active = 0;
    end else begin
      if (!active && (pmem_read || pmem_write)) begin
        pi = (pend_i.size() > 0) && (pend_i[0].raise_cycle < cyc);
        pd = (pend_d.size() > 0) && (pend_d[0].raise_cycle < cyc);
        first = 1 << 30;
        if (pend_i.size() > 0 && pend_i[0].raise_cycle + 1 < first) first = pend_i[0].raise_cycle + 1;
        if (pend_d.size() > 0 && pend_d[0].raise_cycle + 1 < first) first = pend_d[0].raise_cycle + 1;
        g_exp = (first > earliest_grant) ? first : earliest_grant;
        if (!pi && !pd) begin
          checkOutput("grant_without_request", 256'(pmem_read | pmem_write), 256'(0));
        end else begin
          checkOutput("grant_cycle", 256'(cyc), 256'(g_exp));
          cur_side = (pi && pd) ? (1 - last_served) : (pd ? 1 : 0);
          active = 1;
          grant_log.push_back(cur_side);
        end
      end
      if (active && ((cur_side == 0 && pend_i.size() > 0) || (cur_side == 1 && pend_d.size() > 0))) begin
        r = (cur_side == 1) ? pend_d[0] : pend_i[0];
        checkOutput("pmem_address", 256'(pmem_address), 256'(lineBase(r.addr)));
        checkOutput("pmem_read", 256'(pmem_read), 256'(r.rd && !r.wr));
        checkOutput("pmem_write", 256'(pmem_write), 256'(r.wr));
        if (cur_side == 1) checkOutput("pmem_wdata", pmem_wdata, r.wdata);
        checkOutput("rdata_other", (cur_side == 1) ? icache_pmem_rdata : dcache_pmem_rdata, '0);
        checkOutput("resp_other", 256'((cur_side == 1) ? icache_pmem_resp : dcache_pmem_resp), 256'(0));
        if (pmem_resp) begin
          checkOutput("resp_granted", 256'((cur_side == 1) ? dcache_pmem_resp : icache_pmem_resp), 256'(1));
          checkOutput("rdata_granted", (cur_side == 1) ? dcache_pmem_rdata : icache_pmem_rdata, mem_line);
          if (cur_side == 1) pend_d.delete(0);
          else pend_i.delete(0);
          last_served    = cur_side;
          earliest_grant = cyc + 3;
          active         = 0;
        end else begin
          checkOutput("resp_early", 256'((cur_side == 1) ? dcache_pmem_resp : icache_pmem_resp), 256'(0));
        end
      end else if (!active && !(pmem_read || pmem_write)) begin
        checkOutput("idle_resp", 256'({icache_pmem_resp, dcache_pmem_resp}), 256'(0));
      end
    end
  end

  initial begin
    int w;
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 500000 ns");
    n_fail = n_fail + 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_order[6];
    int w;
    exp_order = '{1, 0, 1, 0, 1, 0};
    rst = 1'b1;
    icache_pmem_read = 1'b0; icache_pmem_address = '0;
    dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    dcache_pmem_address = '0; dcache_pmem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    last_served = 0;
    earliest_grant = cyc + 1;
    @(negedge clk);
    checkOutput("reset_pmem_req", 256'({pmem_read, pmem_write}), 256'(0));
    checkOutput("reset_pmem_address", 256'(pmem_address), 256'(0));
    checkOutput("reset_pmem_wdata", pmem_wdata, '0);

    $display("[TB] both sides continuously requesting from reset");
    grant_log.delete();
    fork
      randomTraffic(0, 3, 0);
      randomTraffic(1, 3, 0);
    join
    checkOutput("alternate_count", 256'(grant_log.size()), 256'(6));
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      checkOutput($sformatf("alternate_order_%0d", k), 256'(grant_log[k]), 256'(exp_order[k]));

    $display("[TB] directed single transfers");
    mem_delay = 3;
    applyStimulus(0, 32'h0000_1234, 1'b1, 1'b0, '0);
    applyStimulus(1, 32'h8000_00FF, 1'b0, 1'b1, {32{8'hA5}});
    applyStimulus(1, 32'h0000_0040, 1'b1, 1'b1, {8{32'h1234_5678}});

    $display("[TB] D request arrives while I is being served");
    mem_delay = 6;
    fork
      applyStimulus(0, 32'h0000_2001, 1'b1, 1'b0, '0);
      begin
        repeat (3) @(posedge clk);
        applyStimulus(1, 32'h0000_3003, 1'b1, 1'b0, '0);
      end
    join

    $display("[TB] random traffic");
    mem_delay = 0;
    fork
      randomTraffic(0, 25, 6);
      randomTraffic(1, 25, 6);
    join

    $display("[TB] reset in the middle of a D transfer");
    auto_mem = 0;
    @(posedge clk); #1;
    begin
      req_t r;
      r.addr = 32'h0000_4444; r.rd = 1'b0; r.wr = 1'b1; r.wdata = randLine(); r.raise_cycle = cyc;
      pend_d.push_back(r);
      dcache_pmem_write   = 1'b1;
      dcache_pmem_address = r.addr;
      dcache_pmem_wdata   = r.wdata;
    end
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!pmem_write && w < 20);
    checkOutput("rst_test_grant", 256'(pmem_write), 256'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    dcache_pmem_write = 1'b0;
    pend_d.delete();
    pend_i.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    last_served = 0;
    earliest_grant = cyc + 1;
    grant_log.delete();
    @(negedge clk);
    checkOutput("after_rst_pmem_req", 256'({pmem_read, pmem_write}), 256'(0));
    checkOutput("after_rst_pmem_address", 256'(pmem_address), 256'(0));
    checkOutput("after_rst_pmem_wdata", pmem_wdata, '0);
    checkOutput("after_rst_resp", 256'({icache_pmem_resp, dcache_pmem_resp}), 256'(0));
    @(posedge clk); #1;
    pmem_resp  = 1'b1;
    pmem_rdata = randLine();
    @(negedge clk);
    checkOutput("late_resp_ignored", 256'(dcache_pmem_resp), 256'(0));
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    auto_mem  = 1;
    fork
      applyStimulus(0, $urandom, 1'b1, 1'b0, '0);
      applyStimulus(1, $urandom, 1'b1, 1'b0, '0);
    join
    checkOutput("post_rst_count", 256'(grant_log.size()), 256'(2));
    if (grant_log.size() > 0) checkOutput("post_rst_first_is_d", 256'(grant_log[0]), 256'(1));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Arbitrates the single physical-memory line port between the instruction cache (read-only) and the data cache (read/write) of the pipelined RV32I core.
- Sits between the two cache miss interfaces and the burst/pmem interface.
- One transaction is in flight at a time.
- Ties are broken round-robin so neither fetch nor load/store traffic starves.

Parameters:
- ADDR_WIDTH, 32, byte-address width of all address ports.
- LINE_WIDTH, 256, cache line width in bits.
- OFFSET_BITS, 5, low address bits zeroed on pmem_address (log2 of LINE_WIDTH/8).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- icache_pmem_read  in  1  I-cache line fill request, held until icache_pmem_resp
- icache_pmem_address  in  ADDR_WIDTH  I-cache request address
- icache_pmem_rdata  out  LINE_WIDTH  fill data to I-cache
- icache_pmem_resp  out  1  one-cycle completion pulse to I-cache
- dcache_pmem_read  in  1  D-cache fill request, held until dcache_pmem_resp
- dcache_pmem_write  in  1  D-cache writeback request, held until dcache_pmem_resp
- dcache_pmem_address  in  ADDR_WIDTH  D-cache request address
- dcache_pmem_wdata  in  LINE_WIDTH  D-cache writeback line
- dcache_pmem_rdata  out  LINE_WIDTH  fill data to D-cache
- dcache_pmem_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  memory read request
- pmem_write  out  1  memory write request
- pmem_address  out  ADDR_WIDTH  line-aligned memory address
- pmem_wdata  out  LINE_WIDTH  memory write line
- pmem_rdata  in  LINE_WIDTH  memory read line
- pmem_resp  in  1  memory completion pulse

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, DONE. Reset forces IDLE and last_grant=I, so the first tie goes to D.
- Output reset values: pmem_read/pmem_write/icache_pmem_resp/dcache_pmem_resp = 0; pmem_address = 0; pmem_wdata = 0.
- Reset mid-transaction abandons the transfer: no resp is issued and any late pmem_resp is ignored while in IDLE.
- IDLE transitions:
  - only I requesting -> SERVE_I
  - only D requesting (read or write) -> SERVE_D
  - both requesting -> the side opposite last_grant
  - none -> stay in IDLE
- IDLE drives no pmem request.
- Grant latency: a request present at edge N has pmem_read/pmem_write asserted during cycle N+1.
- SERVE_I:
  - pmem_read=1, pmem_write=0
  - pmem_address = icache_pmem_address with [OFFSET_BITS-1:0] zeroed
- SERVE_D:
  - pmem_read = dcache_pmem_read & ~dcache_pmem_write
  - pmem_write = dcache_pmem_write (write wins if both are asserted)
  - pmem_address = aligned dcache_pmem_address
  - pmem_wdata = dcache_pmem_wdata
- Address and wdata are combinational from the granted requester. Requesters hold them stable until resp.
- Completion: in a SERVE state with pmem_resp=1:
  - the granted side's *_resp=1 in that same cycle (combinational pass-through)
  - *_rdata = pmem_rdata in that cycle
  - last_grant <= served side; next state DONE
- The non-granted side's resp is never asserted. Non-granted rdata is driven 0.
- DONE: exactly one cycle with no pmem request and no resp, so the requester can drop or re-issue its request. Then -> IDLE.
- A request arriving while the other side is served waits.
- Maximum wait is one full transaction of the other side plus 2 cycles of arbiter overhead.
- Continuous requests from both sides alternate strictly: D, I, D, I, …
- A requester dropping its request before resp is a protocol violation; behaviour is undefined.
- pmem_resp received outside a SERVE state is ignored.

Test Plan:
- I read alone, addr 0x0000_1234, pmem_resp 3 cycles after grant:
  - pmem_read high from the cycle after request
  - pmem_address=0x0000_1220
  - icache_pmem_resp one cycle with rdata=pmem_rdata
  - DONE lasts one cycle
- D write alone, addr 0x8000_00FF, wdata pattern A5…:
  - pmem_write=1, pmem_read=0
  - pmem_address=0x8000_00E0, pmem_wdata=A5…
  - dcache_pmem_resp pulses once
  - icache_pmem_resp stays 0
- I and D asserted simultaneously from reset: D served first, I served next; grant gap is 2 cycles (DONE+IDLE).
- Both held continuously for 6 transactions: grant order D,I,D,I,D,I; no two consecutive grants to the same side.
- D request arrives while SERVE_I is waiting on pmem: pmem_address stays on I until its resp, then D is granted; D resp does not appear early.
- rst asserted mid SERVE_D, with pmem_resp arriving 2 cycles later:
  - all outputs 0 the next cycle, state IDLE
  - no dcache_pmem_resp is issued
  - after rst, a tie grants D first
